// File: rtl/markov_table_merge.sv
// Merge engine for Markov chain tables: folds a stream of (key, count) entries
// into one table, summing counts of equal keys with saturation.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ACCEPT | ready for the next entry
// SEARCH | comparing the latched entry against one row per cycle
// DONE   | merge finished, table stable until the next start
module markov_table_merge #(
    parameter int SEQ_W = 24,
    parameter int CNT_W = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int UW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEQ_W-1:0] in_key,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic             in_last,
    output logic             done,
    output logic [UW-1:0]    used,
    output logic             overflow,
    output logic             saturated,
    input  logic [AW-1:0]    rd_addr,
    output logic [SEQ_W-1:0] rd_key,
    output logic [CNT_W-1:0] rd_cnt
);

    typedef enum logic [1:0] {IDLE, ACCEPT, SEARCH, DONE} state_t;

    state_t state, state_nxt;

    logic [SEQ_W-1:0] row_key [DEPTH];
    logic [CNT_W-1:0] row_cnt [DEPTH];

    logic [SEQ_W-1:0] lkey;
    logic [CNT_W-1:0] lcnt;
    logic             llast;
    logic [UW-1:0]    idx;

    logic [AW-1:0]    idx_a;
    logic [AW-1:0]    used_a;
    logic             in_range;
    logic             hit;
    logic             room;
    logic             accept_hs;
    logic             search_end;
    logic [CNT_W:0]   sum;

    assign idx_a      = idx[AW-1:0];
    assign used_a     = used[AW-1:0];
    assign in_range   = idx < used;
    assign hit        = in_range && (row_key[idx_a] == lkey);
    assign room       = used < UW'(DEPTH);
    assign sum        = {1'b0, row_cnt[idx_a]} + {1'b0, lcnt};
    assign accept_hs  = (state == ACCEPT) && in_valid;
    assign search_end = (state == SEARCH) && (hit || !in_range);

    assign in_ready = (state == ACCEPT);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACCEPT;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                ACCEPT: begin
                    if (in_valid) begin
                        if (in_cnt == '0) begin
                            state_nxt = in_last ? DONE : ACCEPT;
                        end else begin
                            state_nxt = SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (search_end) begin
                        state_nxt = llast ? DONE : ACCEPT;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Table rows beyond 'used' are stale after a start; they are never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            used      <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            idx       <= '0;
            lkey      <= '0;
            lcnt      <= '0;
            llast     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                row_key[i] <= '0;
                row_cnt[i] <= '0;
            end
        end else if (start) begin
            used      <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            idx       <= '0;
        end else begin
            if (accept_hs) begin
                lkey  <= in_key;
                lcnt  <= in_cnt;
                llast <= in_last;
                idx   <= '0;
            end
            if (state == SEARCH) begin
                if (hit) begin
                    row_cnt[idx_a] <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                    if (sum[CNT_W]) begin
                        saturated <= 1'b1;
                    end
                end else if (in_range) begin
                    idx <= idx + UW'(1);
                end else if (room) begin
                    row_key[used_a] <= lkey;
                    row_cnt[used_a] <= lcnt;
                    used            <= used + UW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Registered read port; rows at or beyond 'used' read as empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_key <= '0;
            rd_cnt <= '0;
        end else if (UW'(rd_addr) < used) begin
            rd_key <= row_key[rd_addr];
            rd_cnt <= row_cnt[rd_addr];
        end else begin
            rd_key <= '0;
            rd_cnt <= '0;
        end
    end

endmodule

// File: doc/markov_table_merge.md
Name: markov_table_merge

Overview:
- Parametrised merge engine for Markov chain tables: accepts a stream of (sequence key, count) entries from any number of learned source tables and builds one combined table.
- Entries with equal keys are combined into one row by summing their counts.
- Generalises the fixed two-level, four-table merge tree into a single engine with configurable key/count width and table depth.
- Sits after the per-fragment learning blocks; the output table is read back through a registered read port.

Parameters:
SEQ_W, 24, key width in bits (SEQUENCE_LEN*(NOTE_BIT_LEN+DELAY_BIT_LEN)).
CNT_W, 4, occurrence count width in bits.
DEPTH, 16, merged table capacity in entries.
AW, $clog2(DEPTH), read address width.
UW, $clog2(DEPTH+1), used-count width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; clears the table and begins a merge.
in_valid  in  1  input entry valid.
in_ready  out  1  engine can accept an entry this cycle.
in_key  in  SEQ_W  sequence key.
in_cnt  in  CNT_W  occurrence count; 0 means an empty slot.
in_last  in  1  marks the final entry of the merge.
done  out  1  merge complete; held high until the next start.
used  out  UW  number of occupied rows.
overflow  out  1  sticky; a new key was dropped because the table was full.
saturated  out  1  sticky; at least one count sum was clamped.
rd_addr  in  AW  read address.
rd_key  out  SEQ_W  key at rd_addr, registered.
rd_cnt  out  CNT_W  count at rd_addr, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - in_ready=0, done=0, used=0, overflow=0, saturated=0.
  - rd_key=0, rd_cnt=0.
  - All table rows cleared to key 0, count 0.
- States: IDLE, ACCEPT, SEARCH, DONE.
- start has priority in every state. It sets used=0, overflow=0, saturated=0 and done=0, then moves to ACCEPT next cycle. Any entry in flight is discarded. Row contents need not be cleared, because rows at index >= used are invalid.
- IDLE: in_ready=0. Waits for start.
- ACCEPT: in_ready=1, combinationally equal to (state==ACCEPT).
  - A handshake (in_valid & in_ready) latches key, cnt and last.
  - If in_cnt==0: the entry is ignored. Go to DONE if last, else stay in ACCEPT.
  - Otherwise: idx=0, go to SEARCH.
- SEARCH: in_ready=0. One row is compared per cycle.
  - idx<used and key[idx]==lkey: cnt[idx] = min(cnt[idx]+lcnt, 2^CNT_W-1). Set saturated if clamped. The search ends.
  - idx<used and no match: idx++, stay in SEARCH.
  - idx==used and used<DEPTH: write row[used]={lkey,lcnt}, used++. The search ends.
  - idx==used and used==DEPTH: drop the entry, set overflow. The search ends.
  - On search end: go to DONE if the latched last=1, else return to ACCEPT.
- Throughput:
  - An entry matching row k occupies k+1 SEARCH cycles.
  - A new key occupies used+1 SEARCH cycles.
  - Each entry is preceded by 1 ACCEPT cycle.
- DONE: done=1, in_ready=0. Rows and flags are stable. Leaves only on start.
- Sum width: the adder is CNT_W+1 bits; clamp to all-ones on a carry.
- used updates on the same edge as the row write, so it is visible the next cycle.
- Read port: rd_key/rd_cnt update one cycle after rd_addr is sampled.
  - When rd_addr>=used, both outputs are 0.
  - Reads are legal in any state. A read of a row written on the same edge returns the old contents.
- in_key/in_cnt/in_last are sampled only on a handshake. Values outside a handshake are don't-care.

Test Plan:
1. Reset low mid-SEARCH (used=5) -> same cycle: in_ready=0, done=0, used=0, flags 0; rd_cnt reads 0 at addr 0 afterwards.
2. start; stream keys 0x000111 cnt2, 0x000222 cnt3, 0x000111 cnt4 (last) -> used=2, row0={0x000111,6}, row1={0x000222,3}, done=1, saturated=0; third entry takes 1 SEARCH cycle.
3. start; key 0xABCDEF cnt 12 then same key cnt 9 (last) -> row0 cnt=15, saturated=1, used=1.
4. start; 17 distinct keys, cnt 1 each, last on 17th -> used=16, overflow=1, 17th key absent from rows 0-15, done=1.
5. start; entries cnt0, then key 0x000333 cnt1, then cnt0 with last -> zero-count entries ignored, used=1, done asserted 1 cycle after the last handshake.
6. In DONE with used=3, pulse start; stream one new key cnt5 (last) -> used=1, row0 holds the new key, rd_addr=1 returns 0/0; start pulsed mid-SEARCH discards the in-flight entry.
